// File: rtl/uart_tx_word_sequencer_pkg.sv
// Shared definitions for the UART word sequencer: FSM state encoding and
// the byte-count helpers used to size the per-word byte counter.
package uart_tx_word_sequencer_pkg;

  // One-hot state encoding, same style as the transmitter this block feeds.
  localparam int         STATE_W = 4;
  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_SEND = 4'b0010;
  localparam logic [3:0] ST_WAIT = 4'b0100;
  localparam logic [3:0] ST_DONE = 4'b1000;

  // Per-requester vector (requester 0 in bit 0, requester 1 in bit 1).
  typedef logic [1:0] req_vec_t;

  // Number of transmitter bytes that make up one requester word.
  function automatic int calc_nb_bytes(input int nb_word, input int nb_data);
    return nb_word / nb_data;
  endfunction

  // Byte counter width; at least one bit even when a word is a single byte.
  function automatic int calc_cnt_w(input int nb_bytes);
    return (nb_bytes > 1) ? $clog2(nb_bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter. Purely combinational: when only one requester
// is valid it wins; when both are valid the one that did not win last time
// gets the grant.
module uart_rr_arb2
  import uart_tx_word_sequencer_pkg::*;
(
  input  req_vec_t i_valid,
  input  logic     i_last_grant,
  output logic     o_grant_valid,
  output logic     o_grant_id,
  output req_vec_t o_grant_onehot
);

  // Pick the winner from the valid vector and the previous winner.
  always_comb begin
    o_grant_valid  = |i_valid;
    o_grant_id     = 1'b0;
    case (i_valid)
      2'b01:   o_grant_id = 1'b0;
      2'b10:   o_grant_id = 1'b1;
      2'b11:   o_grant_id = ~i_last_grant;
      default: o_grant_id = 1'b0;
    endcase
    o_grant_onehot = 2'b00;
    if (o_grant_valid) begin
      o_grant_onehot = o_grant_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/uart_tx_word_sequencer.sv
// Shares one UART transmitter between two word-wide requesters. A word is
// granted round-robin, then sent LSB byte first; each byte gets a start pulse
// and the next byte waits for the transmitter's done pulse.
module uart_tx_word_sequencer
  import uart_tx_word_sequencer_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_WORD = 32
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [1:0]         i_req_valid,
  input  logic [NB_WORD-1:0] i_req_data0,
  input  logic [NB_WORD-1:0] i_req_data1,
  output logic [1:0]         o_req_ready,
  output logic [1:0]         o_word_done,
  output logic               o_start_tx,
  output logic [NB_DATA-1:0] o_tx_data,
  input  logic               i_txdone,
  output logic               o_busy
);

  localparam int               NB_BYTES  = calc_nb_bytes(NB_WORD, NB_DATA);
  localparam int               CNT_W     = calc_cnt_w(NB_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NB_BYTES - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [NB_WORD-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_id_q, grant_id_d;

  logic               arb_valid;
  logic               arb_id;
  req_vec_t           arb_onehot;
  logic               in_idle;
  logic               accept;
  logic [NB_WORD-1:0] granted_word;

  uart_rr_arb2 u_arb (
    .i_valid        (i_req_valid),
    .i_last_grant   (last_grant_q),
    .o_grant_valid  (arb_valid),
    .o_grant_id     (arb_id),
    .o_grant_onehot (arb_onehot)
  );

  // Ready is only offered in IDLE, and never while reset is held low.
  assign in_idle      = (state_q == ST_IDLE);
  assign o_req_ready  = (in_idle && i_reset) ? arb_onehot : 2'b00;
  assign accept       = in_idle && arb_valid;
  assign granted_word = arb_id ? i_req_data1 : i_req_data0;

  // Next-state logic: accept a word, emit its bytes one per txdone, then retire.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d      = granted_word;
          grant_id_d   = arb_id;
          last_grant_d = arb_id;
          byte_cnt_d   = '0;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_txdone) begin
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = ST_DONE;
          end else begin
            shift_d    = shift_q >> NB_DATA;
            byte_cnt_d = byte_cnt_q + 1'b1;
            state_d    = ST_SEND;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any word in flight and favours requester 0 next.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
    end
  end

  // The low byte of the shift register is the byte on the wire; it only moves
  // on accept or after a txdone, so it stays stable for the whole byte time.
  assign o_tx_data   = shift_q[NB_DATA-1:0];
  assign o_start_tx  = (state_q == ST_SEND);
  assign o_word_done = (state_q == ST_DONE) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_busy      = !in_idle;

endmodule

// File: tb/tb_uart_tx_word_sequencer.sv
// Bench for uart_tx_word_sequencer: a requester driver, a transmitter model,
// and a scoreboard monitor comparing every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_uart_tx_word_sequencer;

  localparam int NB_DATA  = 8;
  localparam int NB_WORD  = 32;
  localparam int NB_BYTES = NB_WORD / NB_DATA;

  logic               clk = 1'b0;
  logic               i_reset = 1'b0;
  logic [1:0]         i_req_valid = 2'b00;
  logic [NB_WORD-1:0] i_req_data0 = '0;
  logic [NB_WORD-1:0] i_req_data1 = '0;
  logic [1:0]         o_req_ready;
  logic [1:0]         o_word_done;
  logic               o_start_tx;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_txdone = 1'b0;
  logic               o_busy;

  // Byte-wide instance for the single-byte-word case.
  logic [1:0] v8 = 2'b00;
  logic [7:0] d8_0 = 8'h00;
  logic [7:0] d8_1 = 8'h00;
  logic [1:0] ready8;
  logic [1:0] done8;
  logic       start8;
  logic [7:0] txd8;
  logic       txdone8 = 1'b0;
  logic       busy8;

  uart_tx_word_sequencer #(.NB_DATA(NB_DATA), .NB_WORD(NB_WORD)) dut (
    .clk(clk), .i_reset(i_reset), .i_req_valid(i_req_valid),
    .i_req_data0(i_req_data0), .i_req_data1(i_req_data1),
    .o_req_ready(o_req_ready), .o_word_done(o_word_done),
    .o_start_tx(o_start_tx), .o_tx_data(o_tx_data),
    .i_txdone(i_txdone), .o_busy(o_busy)
  );

  uart_tx_word_sequencer #(.NB_DATA(8), .NB_WORD(8)) dut8 (
    .clk(clk), .i_reset(i_reset), .i_req_valid(v8),
    .i_req_data0(d8_0), .i_req_data1(d8_1),
    .o_req_ready(ready8), .o_word_done(done8),
    .o_start_tx(start8), .o_tx_data(txd8),
    .i_txdone(txdone8), .o_busy(busy8)
  );

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  // Stimulus-side knobs.
  logic [NB_WORD-1:0] words0[$];
  logic [NB_WORD-1:0] words1[$];
  int  words_issued = 0;
  int  tx_delay = 0;
  bit  spur_txdone = 1'b0;
  bit  spur_in_send = 1'b0;

  // Observations logged by the monitor.
  int     n_starts = 0;
  int     n_done = 0;
  bit     grant_log[$];
  longint acc_cyc_log[$];
  longint done_cyc_log[$];

  // Reference model state.
  logic [7:0] exp_byte_q[$];
  longint     exp_start_q[$];
  longint     exp_done_cyc_q[$];
  bit         exp_done_id_q[$];
  bit         model_free;
  bit         model_last;
  bit         awaiting;
  int         bytes_left;
  longint     free_at;
  logic [7:0] cur_byte;

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit req, input logic [NB_WORD-1:0] word);
    if (req) words1.push_back(word);
    else     words0.push_back(word);
    words_issued++;
  endtask

  task automatic waitDone(input string name, input int target, input int budget);
    int n = 0;
    while (n_done < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput(name, 64'(n_done >= target), 64'(1));
  endtask

  task automatic modelReset();
    exp_byte_q.delete();
    exp_start_q.delete();
    exp_done_cyc_q.delete();
    exp_done_id_q.delete();
    model_free = 1'b1;
    model_last = 1'b1;
    awaiting   = 1'b0;
    bytes_left = 0;
    free_at    = -1;
    cur_byte   = 8'h00;
  endtask

  // Requester driver: each requester presents the head of its queue and
  // drops it once the handshake has been seen.
  initial begin
    logic [1:0] acc;
    forever begin
      @(negedge clk);
      acc = i_req_valid & o_req_ready;
      @(posedge clk);
      #1;
      if (acc[0] && words0.size() > 0) void'(words0.pop_front());
      if (acc[1] && words1.size() > 0) void'(words1.pop_front());
      i_req_valid[0] = (words0.size() > 0);
      i_req_valid[1] = (words1.size() > 0);
      i_req_data0    = (words0.size() > 0) ? words0[0] : '0;
      i_req_data1    = (words1.size() > 0) ? words1[0] : '0;
    end
  end

  // Transmitter model: answers each start pulse with a txdone some cycles later,
  // plus optional spurious pulses requested by the stimulus.
  initial begin
    int countdown = 0;
    bit fire;
    forever begin
      @(posedge clk);
      #2;
      if (!i_reset) begin
        countdown = 0;
        i_txdone  = 1'b0;
        continue;
      end
      fire = (countdown == 1);
      if (countdown > 0) countdown--;
      if (o_start_tx) begin
        if (countdown != 0) checkOutput("start_overlaps_byte", 64'(countdown), 64'(0));
        countdown = (tx_delay == 0) ? int'($urandom_range(20, 1)) : tx_delay;
      end
      i_txdone = fire | spur_txdone | (spur_in_send & o_start_tx);
    end
  end

  // Scoreboard monitor: the model decides when ready, start, done and busy
  // should appear and which byte each start must carry.
  initial begin
    longint     c;
    bit         exp_start;
    bit         g;
    logic [1:0] exp_ready;
    logic [1:0] exp_done;
    logic [NB_WORD-1:0] word;
    modelReset();
    forever begin
      @(negedge clk or negedge i_reset);
      if (!i_reset) begin
        #1;
        modelReset();
        checkOutput("reset_req_ready", 64'(o_req_ready), 64'(0));
        checkOutput("reset_start_tx", 64'(o_start_tx), 64'(0));
        checkOutput("reset_tx_data", 64'(o_tx_data), 64'(0));
        checkOutput("reset_word_done", 64'(o_word_done), 64'(0));
        checkOutput("reset_busy", 64'(o_busy), 64'(0));
        continue;
      end
      c = cyc;
      if (!model_free && free_at == c) model_free = 1'b1;

      if (i_txdone && awaiting) begin
        awaiting = 1'b0;
        bytes_left--;
        if (bytes_left > 0) begin
          exp_start_q.push_back(c + 1);
        end else begin
          exp_done_cyc_q.push_back(c + 1);
          free_at = c + 2;
        end
      end

      exp_start = (exp_start_q.size() > 0) && (exp_start_q[0] == c);
      checkOutput("start_tx", 64'(o_start_tx), 64'(exp_start));
      if (o_start_tx) n_starts++;
      if (exp_start) begin
        void'(exp_start_q.pop_front());
        cur_byte = exp_byte_q.pop_front();
        checkOutput("tx_data", 64'(o_tx_data), 64'(cur_byte));
        awaiting = 1'b1;
      end else if (awaiting) begin
        checkOutput("tx_data_hold", 64'(o_tx_data), 64'(cur_byte));
      end

      exp_done = 2'b00;
      if (exp_done_cyc_q.size() > 0 && exp_done_cyc_q[0] == c) begin
        void'(exp_done_cyc_q.pop_front());
        exp_done = exp_done_id_q.pop_front() ? 2'b10 : 2'b01;
      end
      checkOutput("word_done", 64'(o_word_done), 64'(exp_done));
      if (o_word_done != 2'b00) begin
        n_done++;
        done_cyc_log.push_back(c);
      end

      checkOutput("busy", 64'(o_busy), 64'(!model_free));

      exp_ready = 2'b00;
      g = 1'b0;
      if (model_free && i_req_valid != 2'b00) begin
        g = (i_req_valid == 2'b11) ? !model_last : i_req_valid[1];
        exp_ready = g ? 2'b10 : 2'b01;
      end
      checkOutput("req_ready", 64'(o_req_ready), 64'(exp_ready));
      if ((i_req_valid & o_req_ready) != 2'b00) begin
        grant_log.push_back(o_req_ready[1]);
        acc_cyc_log.push_back(c);
      end
      if (exp_ready != 2'b00) begin
        word = g ? i_req_data1 : i_req_data0;
        for (int i = 0; i < NB_BYTES; i++) exp_byte_q.push_back(8'(word >> (NB_DATA * i)));
        exp_start_q.push_back(c + 1);
        exp_done_id_q.push_back(g);
        model_free = 1'b0;
        model_last = g;
        bytes_left = NB_BYTES;
        free_at    = -1;
      end
    end
  end

  // Directed scenarios, then random traffic, then the single-byte instance.
  initial begin
    int s0;
    int d0;
    int g0;
    int n;
    $display("[TB] start");

    // Contention: both requesters loaded with two words while reset is held.
    applyStimulus(0, 32'h0A0B0C0D);
    applyStimulus(1, 32'h1A1B1C1D);
    applyStimulus(0, 32'h2A2B2C2D);
    applyStimulus(1, 32'h3A3B3C3D);
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b1;
    waitDone("contention_timeout", words_issued, 2000);
    checkOutput("contention_order0", 64'(grant_log[0]), 64'(0));
    checkOutput("contention_order1", 64'(grant_log[1]), 64'(1));
    checkOutput("contention_order2", 64'(grant_log[2]), 64'(0));
    checkOutput("contention_order3", 64'(grant_log[3]), 64'(1));

    // Single word with a fixed 20-cycle transmitter.
    repeat (3) @(posedge clk);
    tx_delay = 20;
    s0 = n_starts;
    applyStimulus(0, 32'hA1B2C3D4);
    waitDone("single_timeout", words_issued, 500);
    checkOutput("single_start_count", 64'(n_starts - s0), 64'(NB_BYTES));
    checkOutput("single_grant", 64'(grant_log[grant_log.size() - 1]), 64'(0));
    repeat (2) @(posedge clk);
    checkOutput("single_busy_after", 64'(o_busy), 64'(0));

    // Back-to-back words from requester 1.
    tx_delay = 0;
    applyStimulus(1, 32'h55AA33CC);
    applyStimulus(1, 32'h0F1E2D3C);
    waitDone("b2b_timeout", words_issued, 1000);
    checkOutput("b2b_gap", 64'(acc_cyc_log[acc_cyc_log.size() - 1] - done_cyc_log[done_cyc_log.size() - 2]), 64'(1));

    // Random traffic from both requesters at random times.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(bit'($urandom_range(1, 0)), $urandom);
      repeat ($urandom_range(30, 0)) @(posedge clk);
    end
    waitDone("random_timeout", words_issued, 5000);

    // Spurious txdone in IDLE and in the start cycle.
    repeat (3) @(posedge clk);
    #1 spur_txdone = 1'b1;
    @(posedge clk);
    #1 spur_txdone = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("spur_idle_busy", 64'(o_busy), 64'(0));
    s0 = n_starts;
    spur_in_send = 1'b1;
    applyStimulus(1, 32'h76543210);
    waitDone("spur_timeout", words_issued, 1000);
    spur_in_send = 1'b0;
    checkOutput("spur_start_count", 64'(n_starts - s0), 64'(NB_BYTES));

    // Reset while the second byte is on the wire.
    repeat (3) @(posedge clk);
    s0 = n_starts;
    d0 = n_done;
    applyStimulus(0, 32'h11223344);
    n = 0;
    while (n_starts < s0 + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("mid_reached_byte2", 64'(n_starts >= s0 + 2), 64'(1));
    @(posedge clk);
    #3 i_reset = 1'b0;
    repeat (2) @(posedge clk);
    checkOutput("mid_no_done", 64'(n_done), 64'(d0));
    words_issued--;
    applyStimulus(1, 32'hCAFEF00D);
    applyStimulus(0, 32'h11223344);
    g0 = grant_log.size();
    @(posedge clk);
    #1 i_reset = 1'b1;
    waitDone("mid_timeout", words_issued, 1000);
    checkOutput("mid_restart_winner", 64'(grant_log[g0]), 64'(0));

    // Single-byte words: one start, done right after the first txdone.
    @(posedge clk);
    #1 v8 = 2'b01; d8_0 = 8'h5A;
    @(negedge clk);
    checkOutput("w8_ready", 64'(ready8), 64'(2'b01));
    @(posedge clk);
    #1 v8 = 2'b00;
    @(negedge clk);
    checkOutput("w8_start", 64'(start8), 64'(1));
    checkOutput("w8_data", 64'(txd8), 64'(8'h5A));
    @(posedge clk);
    @(negedge clk);
    checkOutput("w8_wait_no_start", 64'(start8), 64'(0));
    @(posedge clk);
    #1 txdone8 = 1'b1;
    @(negedge clk);
    checkOutput("w8_done_not_yet", 64'(done8), 64'(0));
    @(posedge clk);
    #1 txdone8 = 1'b0;
    @(negedge clk);
    checkOutput("w8_done", 64'(done8), 64'(2'b01));
    checkOutput("w8_no_second_start", 64'(start8), 64'(0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("w8_busy_low", 64'(busy8), 64'(0));
    checkOutput("w8_idle_start", 64'(start8), 64'(0));

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
